// File: rtl/hex_scan_pkg.sv
// rtl/hex_scan_pkg.sv - shared types and constants for the hex digit scanner
// Contents: scan_state_t slot phase, SEG_BLANK dark pattern, SEG_TABLE nibble
// to active-low {g,f,e,d,c,b,a} segment table (index 0 = nibble 0).
package hex_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Packed so that SEG_TABLE[n] is the pattern for nibble n; listed F down to 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to seven-segment decoder
// Ports: nibble (4-bit hex digit in), seg_n (7-bit active-low {g,f,e,d,c,b,a} out).
module hex_to_seg7
  import hex_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_digit_scanner.sv
// rtl/hex_digit_scanner.sv - time-multiplexed 4-digit seven-segment scanner
// Ports: clk, reset_n (sync active-low), enable (scan enable), hex_value (16-bit
// word, nibble k -> digit k), seg_n / dp_n / digit_en_n (registered active-low
// display drive), frame_tick (pulse when a new snapshot is taken).
// Build option: HEX_SCAN_LEADING_ZERO_BLANK_EN darkens leading-zero digits 1..3.
module hex_digit_scanner
  import hex_scan_pkg::*;
#(
  parameter int DIGIT_PERIOD = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] hex_value,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  digit_en_n,
  output logic        frame_tick
);

  localparam int CW = $clog2(DIGIT_PERIOD);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_PERIOD - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  scan_state_t   state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   snap_q, snap_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    en_q, en_d;
  logic          tick_q, tick_d;
  logic          dp_q;

  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic          lz_dark;

  always_comb begin
    nibble = snap_q[3:0];
    case (idx_q)
      2'd0: nibble = snap_q[3:0];
      2'd1: nibble = snap_q[7:4];
      2'd2: nibble = snap_q[11:8];
      2'd3: nibble = snap_q[15:12];
      default: nibble = snap_q[3:0];
    endcase
  end

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg_n  (dec_seg)
  );

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more significant nibble are 0.
  always_comb begin
    lz_dark = 1'b0;
    case (idx_q)
      2'd1: lz_dark = (snap_q[15:4] == 12'h000);
      2'd2: lz_dark = (snap_q[15:8] == 8'h00);
      2'd3: lz_dark = (snap_q[15:12] == 4'h0);
      default: lz_dark = 1'b0;
    endcase
  end
`else
  assign lz_dark = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    snap_d  = snap_q;
    seg_d   = SEG_BLANK;
    en_d    = 4'hF;
    tick_d  = 1'b0;

    if (!enable) begin
      // Held dark at the start of digit 0 so re-enable takes a fresh snapshot.
      state_d = BLANK;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == '0 && idx_q == 2'd0) begin
            snap_d = hex_value;
            tick_d = 1'b1;
          end
          if (cnt_q == BLANK_LAST) state_d = DRIVE;
        end
        DRIVE: begin
          if (!lz_dark) begin
            en_d  = ~(4'b0001 << idx_q);
            seg_d = dec_seg;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            state_d = BLANK;
          end
        end
        default: state_d = BLANK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= BLANK;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      snap_q  <= 16'h0000;
      seg_q   <= SEG_BLANK;
      en_q    <= 4'hF;
      tick_q  <= 1'b0;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
      tick_q  <= tick_d;
      dp_q    <= 1'b1;
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign digit_en_n = en_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// tb/tb_hex_digit_scanner.sv - self-checking bench for hex_digit_scanner
module tb_hex_digit_scanner;

  localparam int DP = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] hex_value;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  digit_en_n;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;

  hex_digit_scanner #(.DIGIT_PERIOD(DP), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .hex_value  (hex_value),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .digit_en_n (digit_en_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0]      hex;
    logic [3:0][6:0]  seg;   // expected pattern for digit 3..0
    logic [3:0]       lit;   // digit shown during its drive slot
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    chk({tag, " seg_n"}, 32'(seg_n), 32'h7F);
    chk({tag, " digit_en_n"}, 32'(digit_en_n), 32'hF);
    chk({tag, " frame_tick"}, 32'(frame_tick), 32'h0);
    chk({tag, " dp_n"}, 32'(dp_n), 32'h1);
  endtask

  // c counts output cycles since the first enabled edge (c=0 carries the tick).
  task automatic check_cycle(input int c, input vec_t v);
    int slot;
    int pos;
    logic [6:0] es;
    logic [3:0] ee;
    logic       et;
    slot = (c / DP) % 4;
    pos  = c % DP;
    et   = (c % (4 * DP)) == 0;
    if (pos < BC || !v.lit[slot]) begin
      es = 7'h7F;
      ee = 4'hF;
    end else begin
      es = v.seg[slot];
      ee = ~(4'b0001 << slot);
    end
    chk($sformatf("hex=%h c=%0d seg_n", v.hex, c), 32'(seg_n), 32'(es));
    chk($sformatf("hex=%h c=%0d digit_en_n", v.hex, c), 32'(digit_en_n), 32'(ee));
    chk($sformatf("hex=%h c=%0d frame_tick", v.hex, c), 32'(frame_tick), 32'(et));
    chk($sformatf("hex=%h c=%0d dp_n", v.hex, c), 32'(dp_n), 32'h1);
  endtask

  task automatic restart(input logic [15:0] h);
    reset_n   = 1'b0;
    enable    = 1'b1;
    hex_value = h;
    tick();
    reset_n = 1'b1;
  endtask

  logic [3:0] prev_en;

  initial begin
    vecs[0] = '{hex: 16'h1234, seg: {7'h79, 7'h24, 7'h30, 7'h19}, lit: 4'b1111};
    vecs[1] = '{hex: 16'hABCD, seg: {7'h08, 7'h03, 7'h46, 7'h21}, lit: 4'b1111};
    vecs[2] = '{hex: 16'h5678, seg: {7'h12, 7'h02, 7'h78, 7'h00}, lit: 4'b1111};
    vecs[3] = '{hex: 16'h90EF, seg: {7'h10, 7'h40, 7'h06, 7'h0E}, lit: 4'b1111};
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    vecs[4] = '{hex: 16'h0005, seg: {7'h40, 7'h40, 7'h40, 7'h12}, lit: 4'b0001};
`else
    vecs[4] = '{hex: 16'h0005, seg: {7'h40, 7'h40, 7'h40, 7'h12}, lit: 4'b1111};
`endif

    reset_n   = 1'b0;
    enable    = 1'b1;
    hex_value = 16'h1234;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      tick();
      check_dark($sformatf("reset cyc%0d", i));
    end

    // Two full frames per vector: decode, slot timing and 32-cycle tick spacing.
    for (int k = 0; k < 5; k++) begin
      restart(vecs[k].hex);
      for (int c = 0; c < 8 * DP; c++) begin
        tick();
        check_cycle(c, vecs[k]);
      end
    end

    // Write lands during digit 2 drive: current frame keeps the old snapshot.
    restart(16'h1234);
    for (int c = 0; c < 20; c++) begin
      tick();
      check_cycle(c, vecs[0]);
    end
    hex_value = 16'hABCD;
    for (int c = 20; c < 4 * DP; c++) begin
      tick();
      check_cycle(c, vecs[0]);
    end
    for (int c = 4 * DP; c < 8 * DP; c++) begin
      tick();
      check_cycle(c, vecs[1]);
    end

    // Enable dropped mid digit-1 drive, then re-raised with a new word.
    restart(16'h1234);
    for (int c = 0; c < 12; c++) begin
      tick();
      check_cycle(c, vecs[0]);
    end
    enable    = 1'b0;
    hex_value = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_dark($sformatf("enable low cyc%0d", i));
    end
    enable = 1'b1;
    for (int c = 0; c < 5 * DP; c++) begin
      tick();
      check_cycle(c, vecs[2]);
    end

    // Reset mid digit-0 drive overrides on the next edge.
    restart(16'hABCD);
    for (int c = 0; c < 5; c++) begin
      tick();
      check_cycle(c, vecs[1]);
    end
    reset_n = 1'b0;
    tick();
    check_dark("mid reset");
    reset_n = 1'b1;
    for (int c = 0; c < 2 * DP; c++) begin
      tick();
      check_cycle(c, vecs[1]);
    end

    // Random run: one-cold enables, no direct digit-to-digit handoff, dp dark.
    restart(16'h0000);
    prev_en = 4'hF;
    for (int i = 0; i < 400; i++) begin
      hex_value = 16'($urandom);
      enable    = ($urandom_range(0, 19) != 0);
      tick();
      chk($sformatf("rand %0d one-cold", i),
          32'((digit_en_n == 4'hF) || ($countones(~digit_en_n) == 1)), 32'h1);
      chk($sformatf("rand %0d dp_n", i), 32'(dp_n), 32'h1);
      if (prev_en != 4'hF && digit_en_n != 4'hF)
        chk($sformatf("rand %0d handoff", i), 32'(digit_en_n), 32'(prev_en));
      prev_en = digit_en_n;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
